// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Forwarding and stall unit for the decode stage. Each in-flight
//            register writer occupies one entry of a DEPTH-entry shift
//            pipeline (entry 0 = EX, entry DEPTH-1 = WB). Every entry carries
//            a countdown to data-ready, so producers of any latency (ALU,
//            loads, MUL, multi-cycle ops) are handled uniformly.
// Ports    : clk, rst_n              - clock, async active-low reset
//            issue_valid, flush      - decode holds an instruction / squash it
//            rs_*/rt_*               - source addresses, use flags, RF reads
//            wr_en, wr_addr, wr_lat  - destination of the decode instruction
//            stage_data              - result bus per stage (slice i = stage i)
//            rs_data, rt_data        - resolved operands
//            stall                   - hold PC/decode, bubble into EX
//            busy                    - valid bit per entry
//            stall_count             - stall cycle counter (optional)
// Options  : HAZARD_STATS_EN - when defined, stall_count is a free-running
//            32-bit counter of stall cycles; otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int LAT_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid,
    input  logic                    flush,
    input  logic [4:0]              rs_addr,
    input  logic [4:0]              rt_addr,
    input  logic                    rs_used,
    input  logic                    rt_used,
    input  logic                    wr_en,
    input  logic [4:0]              wr_addr,
    input  logic [LAT_W-1:0]        wr_lat,
    input  logic [DATA_W-1:0]       rs_data_rf,
    input  logic [DATA_W-1:0]       rt_data_rf,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    output logic [DATA_W-1:0]       rs_data,
    output logic [DATA_W-1:0]       rt_data,
    output logic                    stall,
    output logic [DEPTH-1:0]        busy,
    output logic [31:0]             stall_count
);

    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAX_REM = DEPTH - 1;

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]            v_q,    v_d;
    logic [DEPTH-1:0][4:0]       addr_q, addr_d;
    logic [DEPTH-1:0][LAT_W-1:0] rem_q,  rem_d;

    // ------------------------------------------------------------------
    // Lookup: youngest (lowest index) matching writer wins
    // ------------------------------------------------------------------
    logic             rs_hit, rt_hit;
    logic [IDX_W-1:0] rs_idx, rt_idx;
    logic             rs_active, rt_active;
    logic             rs_hazard, rt_hazard;
    logic             rs_fwd, rt_fwd;

    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        rs_idx = '0;
        rt_idx = '0;
        // Scan oldest to youngest so the last match (lowest index) sticks.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v_q[i] && (addr_q[i] == rs_addr)) begin
                rs_hit = 1'b1;
                rs_idx = IDX_W'(i);
            end
            if (v_q[i] && (addr_q[i] == rt_addr)) begin
                rt_hit = 1'b1;
                rt_idx = IDX_W'(i);
            end
        end
    end

    // r0 never carries a dependency, and unused sources never stall.
    assign rs_active = rs_used && (rs_addr != 5'd0) && rs_hit;
    assign rt_active = rt_used && (rt_addr != 5'd0) && rt_hit;

    assign rs_hazard = rs_active && (rem_q[rs_idx] != '0);
    assign rt_hazard = rt_active && (rem_q[rt_idx] != '0);
    assign rs_fwd    = rs_active && (rem_q[rs_idx] == '0);
    assign rt_fwd    = rt_active && (rem_q[rt_idx] == '0);

    // A pending (hazard) operand is don't-care; the RF value is driven.
    assign rs_data = rs_fwd ? stage_data[rs_idx*DATA_W +: DATA_W] : rs_data_rf;
    assign rt_data = rt_fwd ? stage_data[rt_idx*DATA_W +: DATA_W] : rt_data_rf;

    // flush squashes the decode instruction, so it can never stall.
    assign stall = issue_valid && !flush && (rs_hazard || rt_hazard);
    assign busy  = v_q;

    // ------------------------------------------------------------------
    // Push and shift
    // ------------------------------------------------------------------
    logic             push;
    logic [31:0]      lat_ext;
    logic [LAT_W-1:0] lat_cap;

    assign push    = issue_valid && wr_en && (wr_addr != 5'd0) && !stall && !flush;
    assign lat_ext = 32'(wr_lat);
    // A result can never be later than WB, so clamp the countdown there.
    assign lat_cap = (lat_ext > 32'(MAX_REM)) ? LAT_W'(MAX_REM) : wr_lat;

    always_comb begin
        v_d    = '0;
        addr_d = '0;
        rem_d  = '0;

        v_d[0]    = push;
        addr_d[0] = push ? wr_addr : 5'd0;
        rem_d[0]  = push ? lat_cap : '0;

        // Entries advance every edge, even while stalled; the countdown
        // decrements as the entry moves and saturates at zero.
        for (int i = 1; i < DEPTH; i++) begin
            v_d[i]    = v_q[i-1];
            addr_d[i] = addr_q[i-1];
            rem_d[i]  = (rem_q[i-1] == '0) ? '0 : (rem_q[i-1] - LAT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            v_q    <= v_d;
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional stall statistics
    // ------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Natural 32-bit wrap from 0xFFFFFFFF to 0.
    assign stall_count_d = stall ? (stall_count_q + 32'd1) : stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Self-checking bench for hazard_scoreboard (DEPTH=4). Expected
//            outputs are queued when stimulus is driven and compared when
//            the outputs are sampled mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int LAT_W  = 3;

    localparam logic [31:0] R1 = 32'h1111_1111;
    localparam logic [31:0] R2 = 32'h2222_2222;

    logic                    clk;
    logic                    rst_n;
    logic                    issue_valid;
    logic                    flush;
    logic [4:0]              rs_addr;
    logic [4:0]              rt_addr;
    logic                    rs_used;
    logic                    rt_used;
    logic                    wr_en;
    logic [4:0]              wr_addr;
    logic [LAT_W-1:0]        wr_lat;
    logic [DATA_W-1:0]       rs_data_rf;
    logic [DATA_W-1:0]       rt_data_rf;
    logic [DEPTH*DATA_W-1:0] stage_data;
    logic [DATA_W-1:0]       rs_data;
    logic [DATA_W-1:0]       rt_data;
    logic                    stall;
    logic [DEPTH-1:0]        busy;
    logic [31:0]             stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic        stall;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [3:0]  busy;
    } exp_t;

    exp_t exp_q[$];

    hazard_scoreboard #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LAT_W  (LAT_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .flush       (flush),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_used     (rs_used),
        .rt_used     (rt_used),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_lat      (wr_lat),
        .rs_data_rf  (rs_data_rf),
        .rt_data_rf  (rt_data_rf),
        .stage_data  (stage_data),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .stall       (stall),
        .busy        (busy),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({e.tag, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
            check_eq({e.tag, ".rs"}, rs_data, e.rs);
            check_eq({e.tag, ".rt"}, rt_data, e.rt);
            check_eq({e.tag, ".busy"}, {28'd0, busy}, {28'd0, e.busy});
        end
    endtask

    task automatic expect_now(input string tag, input logic e_stall, input logic [31:0] e_rs,
                              input logic [31:0] e_rt, input logic [3:0] e_busy);
        exp_q.push_back('{tag, e_stall, e_rs, e_rt, e_busy});
        compare_out();
    endtask

    task automatic drive(input logic iv, input logic fl,
                         input logic [4:0] rsa, input logic rsu,
                         input logic [4:0] rta, input logic rtu,
                         input logic we, input logic [4:0] wa, input logic [2:0] wl);
        issue_valid = iv;
        flush       = fl;
        rs_addr     = rsa;
        rs_used     = rsu;
        rt_addr     = rta;
        rt_used     = rtu;
        wr_en       = we;
        wr_addr     = wa;
        wr_lat      = wl;
    endtask

    // One decode cycle: drive, queue expectation, sample mid-cycle, clock.
    task automatic cyc(input string tag, input logic iv, input logic fl,
                       input logic [4:0] rsa, input logic rsu,
                       input logic [4:0] rta, input logic rtu,
                       input logic we, input logic [4:0] wa, input logic [2:0] wl,
                       input logic e_stall, input logic [31:0] e_rs,
                       input logic [31:0] e_rt, input logic [3:0] e_busy);
        drive(iv, fl, rsa, rsu, rta, rtu, we, wa, wl);
        exp_q.push_back('{tag, e_stall, e_rs, e_rt, e_busy});
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [3:0] e_busy);
        cyc(tag, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, R1, R2, e_busy);
    endtask

    task automatic push_wr(input string tag, input logic [4:0] wa, input logic [2:0] wl,
                           input logic [3:0] e_busy);
        cyc(tag, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, wa, wl, 1'b0, R1, R2, e_busy);
    endtask

    task automatic set_stage(input int idx, input logic [31:0] val);
        stage_data[idx*DATA_W +: DATA_W] = val;
    endtask

    initial begin
        rst_n      = 1'b0;
        rs_data_rf = R1;
        rt_data_rf = R2;
        for (int i = 0; i < DEPTH; i++) set_stage(i, 32'hA000_0000 + i);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0);

        #1;
        expect_now("reset", 1'b0, R1, R2, 4'b0000);
        check_eq("reset.stall_count", stall_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU back-to-back
        push_wr("alu.push", 5'd5, 3'd0, 4'b0000);
        set_stage(0, 32'h0000_1234);
        cyc("alu.use", 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0,
            1'b0, 32'h0000_1234, R2, 4'b0001);
        idle("alu.drain1", 4'b0010);
        idle("alu.drain2", 4'b0100);
        idle("alu.drain3", 4'b1000);

        // Load-use, one stall cycle
        push_wr("ld.push", 5'd8, 3'd1, 4'b0000);
        cyc("ld.stall", 1'b1, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 3'd0,
            1'b1, R1, R2, 4'b0001);
        set_stage(1, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 3'd0);
        exp_q.push_back('{"ld.fwd", 1'b0, R1, 32'hDEAD_BEEF, 4'b0010});
        @(negedge clk);
        compare_out();
`ifdef HAZARD_STATS_EN
        check_eq("ld.stall_count", stall_count, 32'd1);
`endif
        @(posedge clk);
        #1;
        idle("ld.drain1", 4'b0100);
        idle("ld.drain2", 4'b1000);

        // Youngest wins, both ready
        set_stage(0, 32'h0000_0022);
        set_stage(2, 32'h0000_0011);
        push_wr("yw.old", 5'd3, 3'd0, 4'b0000);
        idle("yw.gap", 4'b0001);
        push_wr("yw.young", 5'd3, 3'd0, 4'b0010);
        cyc("yw.use", 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0,
            1'b0, 32'h0000_0022, R2, 4'b0101);
        idle("yw.drain1", 4'b1010);
        idle("yw.drain2", 4'b0100);
        idle("yw.drain3", 4'b1000);

        // Youngest wins, young one pending despite older ready copy
        push_wr("yp.old", 5'd3, 3'd0, 4'b0000);
        idle("yp.gap", 4'b0001);
        push_wr("yp.young", 5'd3, 3'd2, 4'b0010);
        cyc("yp.use", 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0,
            1'b1, R1, R2, 4'b0101);
        idle("yp.drain1", 4'b1010);
        idle("yp.drain2", 4'b0100);
        idle("yp.drain3", 4'b1000);

        // r0 destination, unused source, flush
        push_wr("z.r0", 5'd0, 3'd0, 4'b0000);
        idle("z.nopush", 4'b0000);
        push_wr("z.push4", 5'd4, 3'd3, 4'b0000);
        cyc("z.unused", 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0,
            1'b0, R1, R2, 4'b0001);
        cyc("z.flush", 1'b1, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 3'd0,
            1'b0, R1, R2, 4'b0010);
        idle("z.noflushpush", 4'b0100);
        idle("z.drain", 4'b1000);

        // Long latency saturates at DEPTH-1
        set_stage(3, 32'hCAFE_F00D);
        push_wr("ll.push", 5'd7, 3'd7, 4'b0000);
        cyc("ll.s1", 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 3'd0, 1'b1, R1, R2, 4'b0001);
        cyc("ll.s2", 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 3'd0, 1'b1, R1, R2, 4'b0010);
        cyc("ll.s3", 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 3'd0, 1'b1, R1, R2, 4'b0100);
        cyc("ll.fwd", 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 3'd0,
            1'b0, R1, 32'hCAFE_F00D, 4'b1000);

        // Reset mid-stream with three writers in flight
        set_stage(0, 32'h5555_AAAA);
        push_wr("rst.w10", 5'd10, 3'd3, 4'b0000);
        push_wr("rst.w11", 5'd11, 3'd3, 4'b0001);
        push_wr("rst.w12", 5'd12, 3'd0, 4'b0011);
        drive(1'b1, 1'b0, 5'd12, 1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 3'd0);
        #1;
        expect_now("rst.before", 1'b1, 32'h5555_AAAA, R2, 4'b0111);
        rst_n = 1'b0;
        #1;
        expect_now("rst.during", 1'b0, R1, R2, 4'b0000);
        check_eq("rst.stall_count", stall_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst.after", 1'b1, 1'b0, 5'd12, 1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 3'd0,
            1'b0, R1, R2, 4'b0000);

        check_eq("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised forwarding and stall unit for the decode stage. It replaces the fixed EX/MEM forward and load-use stall logic.
- Tracks every in-flight register writer in a DEPTH-entry shift pipeline, with a per-entry countdown to data-ready. This supports variable-latency producers: loads, MUL, future multi-cycle ops.
- Sits beside the decode stage: it drives forwarded rs/rt operands and the decode stall, and receives per-stage result buses from EX onward.

Parameters:
- DATA_W, 32, operand/result width
- DEPTH, 4, in-flight stages tracked (index 0 = EX, DEPTH-1 = WB); legal range 2..8
- LAT_W, 3, width of latency field and per-entry countdown

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode holds a valid instruction
- flush  in  1  squash the decode instruction this cycle
- rs_addr  in  5  source register rs
- rt_addr  in  5  source register rt
- rs_used  in  1  instruction reads rs
- rt_used  in  1  instruction reads rt
- wr_en  in  1  instruction writes a register
- wr_addr  in  5  destination register
- wr_lat  in  LAT_W  cycles after entering EX until its result is valid on a stage bus
- rs_data_rf  in  DATA_W  register file rs read
- rt_data_rf  in  DATA_W  register file rt read
- stage_data  in  DEPTH*DATA_W  result bus per stage; slice i = stage i
- rs_data  out  DATA_W  resolved rs operand
- rt_data  out  DATA_W  resolved rt operand
- stall  out  1  hold PC and decode, insert bubble into EX
- busy  out  DEPTH  valid bit per scoreboard entry
- stall_count  out  32  stall cycle counter (see Optional Feature)

Behaviour:
- State: DEPTH entries, each {v, addr[4:0], rem[LAT_W-1:0]}. Only state is entries plus optional counter.
- Reset (async, rst_n=0): all v=0, addr=0, rem=0, stall_count=0. Outputs then: stall=0, busy=0, rs_data=rs_data_rf, rt_data=rt_data_rf.
- Every clock edge, entries advance regardless of stall:
  - entry[i] <= entry[i-1] for i>=1.
  - rem <= (rem==0) ? 0 : rem-1 (saturating).
  - entry[DEPTH-1] retires; the register file must write-before-read in that cycle.
- Push into entry[0], decided per edge:
  - v = issue_valid & wr_en & (wr_addr!=0) & ~stall & ~flush.
  - addr = wr_addr.
  - rem = min(wr_lat, DEPTH-1).
  - Otherwise entry[0] becomes a bubble (v=0).
- Lookup, combinational, done independently for rs and rt (src = rs_addr or rt_addr):
  - If src_used=0 or src==0: operand = RF data, no hazard.
  - Else find the lowest index i with v & addr==src (youngest writer wins).
    - No match: operand = RF data.
    - Match with rem==0: operand = stage_data slice i.
    - Match with rem!=0: hazard; operand = don't care (drive RF data).
- stall = issue_valid & ~flush & (rs_hazard | rt_hazard). flush overrides stall.
- Load-use with wr_lat=1 gives exactly 1 stall cycle; wr_lat=L gives L stall cycles for a dependent instruction issued immediately behind.
- Simultaneous match in several entries: youngest (lowest index) only; older entries are ignored even if ready.
- Reset mid-operation: all in-flight entries are discarded immediately; no partial state survives.
- busy[i] = entry[i].v.
- Latency: push is visible to lookup one cycle after issue (it is in entry[0] on the next cycle).

Optional Feature:
- HAZARD_STATS_EN defined:
  - stall_count is a 32-bit counter, +1 on every cycle with stall=1.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset only.
- Not defined: stall_count tied to 0 and no counter flops; the port list is unchanged.

Test Plan:
- Reset mid-stream: three writers in flight, assert rst_n=0 -> busy=0, stall=0, rs_data=rs_data_rf immediately; after release, the next dependent op has no stall.
- ALU back-to-back: push wr_addr=5, wr_lat=0; next cycle rs_addr=5, stage_data[0]=0x1234 -> stall=0, rs_data=0x1234.
- Load-use: push wr_addr=8, wr_lat=1; next cycle rt_addr=8 -> stall=1 for one cycle; following cycle rt_data=stage_data[1]=0xDEADBEEF, stall=0, HAZARD_STATS_EN stall_count=1.
- Youngest wins: writers to r3 in entry[2] (ready, 0x11) and entry[0] (ready, 0x22) -> rs_data=0x22; same with entry[0] rem=2 -> stall=1 despite older ready copy.
- Zero/unused/flush: wr_addr=0 push -> busy[0]=0; rs_addr=4 matching pending rem=3 entry with rs_used=0 -> stall=0; same with rs_used=1 and flush=1 -> stall=0 and no push.
- Long latency: DEPTH=4, wr_lat=7 saturates to rem=3; dependent op stalls 3 cycles and then forwards from stage_data[3].
